// File: rtl/alu_fwd_pkg.sv
// Shared constants and helpers for the ALU operand forwarding stage.
package alu_fwd_pkg;

  // Operand source codes reported on sel_a / sel_b.
  localparam int SEL_RF       = 0;
  localparam int SEL_IMM      = 1;
  localparam int SEL_FWD_BASE = 2;

  // Width of a source code able to name the register file, the immediate
  // and every forwarding source.
  function automatic int sel_width(input int num_fwd);
    return $clog2(num_fwd + SEL_FWD_BASE);
  endfunction

endpackage

// File: rtl/alu_fwd_pick.sv
// Priority comparator for one ALU operand: finds the youngest forwarding
// source that writes the requested register and returns its data, source
// code, whether any source matched and whether that winner is still pending.
module alu_fwd_pick
  import alu_fwd_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = sel_width(NUM_FWD)
) (
  input  logic [REG_AW-1:0]        idx,
  input  logic [WIDTH-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]       fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]       fwd_pending,
  output logic [WIDTH-1:0]         data,
  output logic [SEL_W-1:0]         code,
  output logic                     match,
  output logic                     pending
);

  // Per-source hit; register 0 is hard-wired and never forwarded.
  logic [NUM_FWD-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FWD; gi++) begin : g_hit
      assign hit[gi] = fwd_we[gi] &&
                       (fwd_addr[gi*REG_AW +: REG_AW] == idx) &&
                       (idx != '0);
    end
  endgenerate

  // Scan oldest to youngest so the lowest index (youngest) is applied last
  // and wins; only that winner's pending flag matters.
  always_comb begin
    data    = rf_data;
    code    = SEL_W'(SEL_RF);
    match   = 1'b0;
    pending = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (hit[i]) begin
        data    = fwd_data[i*WIDTH +: WIDTH];
        code    = SEL_W'(SEL_FWD_BASE + i);
        match   = 1'b1;
        pending = fwd_pending[i];
      end
    end
  end

endmodule

// File: rtl/alu_operand_fwd_stage.sv
// Registered ID/EX operand-selection stage: resolves ALU operands from the
// register file, immediate or forwarding sources, stalls on load-use hazards
// and hands operands to EX over a valid/ready handshake.
module alu_operand_fwd_stage
  import alu_fwd_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [REG_AW-1:0]             rs_idx,
  input  logic [REG_AW-1:0]             rt_idx,
  input  logic [WIDTH-1:0]              rs_data,
  input  logic [WIDTH-1:0]              rt_data,
  input  logic [WIDTH-1:0]              imm,
  input  logic                          use_imm,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0]     fwd_addr,
  input  logic [NUM_FWD*WIDTH-1:0]      fwd_data,
  input  logic [NUM_FWD-1:0]            fwd_pending,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              op_a,
  output logic [WIDTH-1:0]              op_b,
  output logic [sel_width(NUM_FWD)-1:0] sel_a,
  output logic [sel_width(NUM_FWD)-1:0] sel_b,
  output logic                          hazard,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int SEL_W = sel_width(NUM_FWD);

  logic [WIDTH-1:0] pick_a_data;
  logic [SEL_W-1:0] pick_a_code;
  logic             pick_a_match;
  logic             pick_a_pending;
  logic [WIDTH-1:0] pick_b_data;
  logic [SEL_W-1:0] pick_b_code;
  logic             pick_b_match;
  logic             pick_b_pending;

  logic [WIDTH-1:0] op_b_next;
  logic [SEL_W-1:0] sel_b_next;
  logic             free;
  logic             accept;

  alu_fwd_pick #(
    .WIDTH   (WIDTH),
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD),
    .SEL_W   (SEL_W)
  ) u_pick_a (
    .idx         (rs_idx),
    .rf_data     (rs_data),
    .fwd_we      (fwd_we),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .fwd_pending (fwd_pending),
    .data        (pick_a_data),
    .code        (pick_a_code),
    .match       (pick_a_match),
    .pending     (pick_a_pending)
  );

  alu_fwd_pick #(
    .WIDTH   (WIDTH),
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD),
    .SEL_W   (SEL_W)
  ) u_pick_b (
    .idx         (rt_idx),
    .rf_data     (rt_data),
    .fwd_we      (fwd_we),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .fwd_pending (fwd_pending),
    .data        (pick_b_data),
    .code        (pick_b_code),
    .match       (pick_b_match),
    .pending     (pick_b_pending)
  );

  // Operand B: immediate overrides rt and removes rt as a dependency.
  always_comb begin
    op_b_next  = pick_b_data;
    sel_b_next = pick_b_code;
    if (use_imm) begin
      op_b_next  = imm;
      sel_b_next = SEL_W'(SEL_IMM);
    end
  end

  // A load-use hazard exists only when the winning source is still pending.
  assign hazard = in_valid &&
                  ((pick_a_match && pick_a_pending) ||
                   (!use_imm && pick_b_match && pick_b_pending));

  assign free     = !out_valid || out_ready;
  assign in_ready = free && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Output register: flush kills, accept loads, a free slot bubbles, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      sel_a     <= '0;
      sel_b     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      op_a      <= pick_a_data;
      op_b      <= op_b_next;
      sel_a     <= pick_a_code;
      sel_b     <= sel_b_next;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of hazard cycles, flush or not; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/alu_operand_fwd_stage.md
# alu_operand_fwd_stage

Parametrised successor to the ALU operand mux: registered ID/EX operand-selection stage for the MIPS pipeline. It resolves ALU operands A and B from register-file data, the immediate, or any of NUM_FWD forwarding sources using a fixed priority scan. It detects load-use hazards and presents the selected operands to EX through a valid/ready handshake, inserting bubbles when required.

## Interface
Parameters:
- WIDTH, 32, operand/data width
- REG_AW, 5, register index width
- NUM_FWD, 2, forwarding sources; index 0 = youngest stage (EX/MEM), highest priority
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- rs_idx, rt_idx  in  REG_AW  source register indices
- rs_data, rt_data  in  WIDTH  register-file read data
- imm  in  WIDTH  extended immediate
- use_imm  in  1  operand B takes imm; rt is not a dependency
- fwd_we  in  NUM_FWD  source i will write a register
- fwd_addr  in  NUM_FWD*REG_AW  destination of source i, slice i = [i*REG_AW +: REG_AW]
- fwd_data  in  NUM_FWD*WIDTH  result of source i
- fwd_pending  in  NUM_FWD  source i's data not yet available (load in flight)
- flush  in  1  kill the held and incoming instruction
- out_valid  out  1  op_a/op_b valid to EX
- out_ready  in  1  EX consumes this cycle
- op_a, op_b  out  WIDTH  registered operands
- sel_a, sel_b  out  $clog2(NUM_FWD+2)  registered source code
- hazard  out  1  combinational load-use stall indication
- stall_cnt  out  CNT_W  saturating count of hazard cycles

## Operation
- Source codes: 0 = register file, 1 = immediate, 2+i = forwarding source i.
- Operand A: if rs_idx == 0, use rs_data (code 0). Otherwise take the lowest i with fwd_we[i] && fwd_addr[i] == rs_idx. If one is found, use fwd_data[i] (code 2+i). If none is found, use rs_data.
- Operand B: if use_imm, use imm (code 1). Otherwise apply the A rule with rt_idx/rt_data.
- Only the winning (highest-priority) match is considered. An older matching source never overrides a younger one.
- hazard = in_valid && (winning match for A is pending, or winning match for B is pending with !use_imm). Register 0 never hazards.
- Slot free: free = !out_valid || out_ready.
- in_ready = free && !hazard && !flush.
- Load: when in_valid && in_ready, the output register captures op_a, op_b, sel_a and sel_b, and out_valid becomes 1.
- Bubble: when free and the instruction is not accepted, out_valid becomes 0.
- Hold: when out_valid && !out_ready, the outputs are held stable. The held operands are not re-forwarded.
- Flush has priority over load and hold: next cycle out_valid = 0 and nothing is accepted.
- stall_cnt increments each cycle hazard = 1 and saturates at all-ones. It is cleared only by reset.

## Timing
- Reset values: out_valid 0, op_a 0, op_b 0, sel_a 0, sel_b 0, stall_cnt 0. in_ready follows the combinational rule and is 1 after reset when no hazard is present.
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 instruction per cycle while out_ready = 1 and no hazard.
- hazard, in_ready and the selection logic are combinational from the inputs. There is no path from out_ready to op_a.
- A pending source that clears in cycle n allows acceptance in cycle n, with forwarding from the same source.
- Simultaneous hazard and flush: flush wins, and the counter still increments.
- Reset asserted mid-transfer: outputs clear asynchronously and the held instruction is lost.

## Structure
- Package alu_fwd_pkg holds the SEL_RF = 0, SEL_IMM = 1 and SEL_FWD_BASE = 2 constants and the sel-width function.
- Sub-module alu_fwd_pick is instantiated twice, once for A and once for B. It is a parametrised priority comparator returning data, code, match and pending for one operand.
- Top level holds the output register, handshake logic and stall counter.

## Test plan
- No match: rs = 3, rs_data = 0x11, rt = 4, rt_data = 0x22, no fwd_we -> next cycle op_a = 0x11, op_b = 0x22, sel 0/0, out_valid = 1.
- Priority: fwd0 = (r5, 0xAAAA), fwd1 = (r5, 0xBBBB), rs = 5 -> op_a = 0xAAAA, sel_a = 2. With fwd_we[0] = 0 -> op_a = 0xBBBB, sel_a = 3.
- Register 0 and immediate: rs = 0 with fwd0 targeting r0, pending -> op_a = rs_data, no hazard. use_imm = 1, imm = 0xFFFF_FFF0, rt matching a pending source -> op_b = imm, no hazard.
- Load-use: fwd0 = (r7, pending), rs = 7 for 2 cycles -> in_ready = 0, out_valid = 0 bubbles, stall_cnt = 2. Pending clears -> accept with fwd data.
- Backpressure then flush: out_ready = 0 for 3 cycles -> op_a stable and in_ready = 0. Flush -> out_valid = 0 next cycle. Saturation with CNT_W = 2 -> counter holds at 3.
